// File: rtl/ram_wb.sv
// Wishbone classic read/write RAM slave: byte-lane writes, synchronous word reads,
// registered ack/err, error termination on misaligned or out-of-range addresses.
module ram_wb #(
    parameter int DEPTH     = 3072,
    parameter     INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbs_err_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        RESP_NONE = 2'b00,
        RESP_ACK  = 2'b01,
        RESP_ERR  = 2'b10
    } resp_t;

    logic [31:0]   mem [DEPTH];

    resp_t         resp_q, resp_d;
    logic [31:0]   dat_q;
    logic          req;
    logic          bad;
    logic          wr_en;
    logic          rd_en;
    logic [29:0]   word_idx;
    logic [AW-1:0] mem_idx;

    // A pending response blocks a new request, so ack/err never last past one cycle.
    always_comb begin
        word_idx = wbs_adr_i[31:2];
        mem_idx  = word_idx[AW-1:0];
        req      = wbs_cyc_i & wbs_stb_i & (resp_q == RESP_NONE);
        bad      = (wbs_adr_i[1:0] != 2'b00) || ({2'b00, word_idx} >= 32'(DEPTH));
        wr_en    = req & ~bad & wbs_we_i;
        rd_en    = req & ~bad & ~wbs_we_i;

        resp_d = RESP_NONE;
        if (req) begin
            resp_d = bad ? RESP_ERR : RESP_ACK;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_q <= RESP_NONE;
        end else begin
            resp_q <= resp_d;
        end
    end

    // Storage has no reset; the rst gate keeps an in-flight write from landing.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            for (int n = 0; n < 4; n++) begin
                if (wbs_sel_i[n]) begin
                    mem[mem_idx][8*n +: 8] <= wbs_dat_i[8*n +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dat_q <= 32'h0;
        end else if (rd_en) begin
            dat_q <= mem[mem_idx];
        end
    end

    assign wbs_dat_o = dat_q;
    assign wbs_ack_o = (resp_q == RESP_ACK);
    assign wbs_err_o = (resp_q == RESP_ERR);

endmodule

// File: tb/tb_ram_wb.sv
// Directed self-checking bench for ram_wb: reset, word/byte-lane access,
// address boundary errors and reset during an in-flight write.
module tb_ram_wb;

   logic        clock;
   logic        reset;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [3:0]  sel;
   logic [31:0] adr;
   logic [31:0] datIn;
   logic [31:0] datOut;
   logic        ack;
   logic        err;

   int totalChecks = 0;
   int badChecks   = 0;

   // DUT with the default 3072-word depth so the last-word boundary is exercised
   ram_wb #(.DEPTH(3072), .INIT_FILE("")) dut (
      .clk       (clock),
      .rst       (reset),
      .wbs_cyc_i (cyc),
      .wbs_stb_i (stb),
      .wbs_we_i  (we),
      .wbs_sel_i (sel),
      .wbs_adr_i (adr),
      .wbs_dat_i (datIn),
      .wbs_dat_o (datOut),
      .wbs_ack_o (ack),
      .wbs_err_o (err)
   );

   // Free-running 10 ns clock
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Single comparison point: counts every check and reports any difference
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      totalChecks++;
      if (observed !== expected) begin
         badChecks++;
         $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
      end
   endtask

   // One Wishbone transfer: request driven at a falling edge, response sampled 1 ns after
   // the rising edge, request dropped, then the response must clear on the following edge
   task automatic applyStimulus(input logic isWrite, input logic [31:0] address,
                                input logic [3:0] lanes, input logic [31:0] data,
                                output logic gotAck, output logic gotErr, output logic [31:0] gotDat,
                                output logic laterAck, output logic laterErr);
      @(negedge clock);
      cyc   = 1'b1;
      stb   = 1'b1;
      we    = isWrite;
      adr   = address;
      sel   = lanes;
      datIn = data;
      @(posedge clock);
      #1;
      gotAck = ack;
      gotErr = err;
      gotDat = datOut;
      @(negedge clock);
      cyc = 1'b0;
      stb = 1'b0;
      we  = 1'b0;
      @(posedge clock);
      #1;
      laterAck = ack;
      laterErr = err;
   endtask

   logic        a, e, a2, e2;
   logic [31:0] d;

   // Directed sequence with hand-computed expectations
   initial begin
      cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'h0; datIn = 32'h0;

      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      checkOutput("rst_ack", {31'b0, ack}, 32'd0);
      checkOutput("rst_err", {31'b0, err}, 32'd0);
      checkOutput("rst_dat", datOut, 32'h0);
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clock);
         #1;
         checkOutput($sformatf("idle_ack%0d", i), {31'b0, ack}, 32'd0);
      end

      applyStimulus(1'b1, 32'h0, 4'hF, 32'hDEADBEEF, a, e, d, a2, e2);
      checkOutput("wr0_ack", {31'b0, a}, 32'd1);
      checkOutput("wr0_err", {31'b0, e}, 32'd0);
      checkOutput("wr0_ack_drop", {31'b0, a2}, 32'd0);
      applyStimulus(1'b0, 32'h0, 4'h0, 32'h0, a, e, d, a2, e2);
      checkOutput("rd0_ack", {31'b0, a}, 32'd1);
      checkOutput("rd0_dat", d, 32'hDEADBEEF);
      checkOutput("rd0_ack_drop", {31'b0, a2}, 32'd0);

      applyStimulus(1'b1, 32'h0, 4'b0101, 32'h11223344, a, e, d, a2, e2);
      checkOutput("lane_wr_ack", {31'b0, a}, 32'd1);
      applyStimulus(1'b0, 32'h0, 4'hF, 32'h0, a, e, d, a2, e2);
      checkOutput("lane_rd_dat", d, 32'hDE22BE44);

      applyStimulus(1'b1, 32'h0, 4'b0000, 32'h55555555, a, e, d, a2, e2);
      checkOutput("sel0_wr_ack", {31'b0, a}, 32'd1);
      applyStimulus(1'b0, 32'h0, 4'h0, 32'h0, a, e, d, a2, e2);
      checkOutput("sel0_rd_dat", d, 32'hDE22BE44);

      applyStimulus(1'b1, 32'd3071 * 4, 4'hF, 32'h916142D8, a, e, d, a2, e2);
      checkOutput("last_wr_ack", {31'b0, a}, 32'd1);
      checkOutput("last_wr_err", {31'b0, e}, 32'd0);
      applyStimulus(1'b0, 32'd3071 * 4, 4'h0, 32'h0, a, e, d, a2, e2);
      checkOutput("last_rd_dat", d, 32'h916142D8);
      applyStimulus(1'b0, 32'd3072 * 4, 4'h0, 32'h0, a, e, d, a2, e2);
      checkOutput("oob_err", {31'b0, e}, 32'd1);
      checkOutput("oob_ack", {31'b0, a}, 32'd0);
      checkOutput("oob_dat_hold", d, 32'h916142D8);
      checkOutput("oob_err_drop", {31'b0, e2}, 32'd0);

      applyStimulus(1'b1, 32'h4, 4'hF, 32'hA5A5_0F0F, a, e, d, a2, e2);
      checkOutput("pre4_wr_ack", {31'b0, a}, 32'd1);
      applyStimulus(1'b1, 32'h6, 4'hF, 32'hFFFFFFFF, a, e, d, a2, e2);
      checkOutput("mis_err", {31'b0, e}, 32'd1);
      checkOutput("mis_ack", {31'b0, a}, 32'd0);
      applyStimulus(1'b0, 32'h4, 4'h0, 32'h0, a, e, d, a2, e2);
      checkOutput("mis_rd4_dat", d, 32'hA5A5_0F0F);

      applyStimulus(1'b1, 32'h8, 4'hF, 32'h12345678, a, e, d, a2, e2);
      checkOutput("pre8_wr_ack", {31'b0, a}, 32'd1);
      @(negedge clock);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h8; sel = 4'hF; datIn = 32'hCAFEF00D;
      reset = 1'b1;
      @(posedge clock);
      #1;
      checkOutput("rstmid_ack", {31'b0, ack}, 32'd0);
      checkOutput("rstmid_dat", datOut, 32'h0);
      @(negedge clock);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      reset = 1'b0;
      applyStimulus(1'b0, 32'h8, 4'h0, 32'h0, a, e, d, a2, e2);
      checkOutput("rstmid_rd_ack", {31'b0, a}, 32'd1);
      checkOutput("rstmid_rd_dat", d, 32'h12345678);

      // Held strobe: the acknowledge must alternate while the request stays up
      @(negedge clock);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h8;
      for (int i = 0; i < 4; i++) begin
         @(posedge clock);
         #1;
         checkOutput($sformatf("hold_ack%0d", i), {31'b0, ack}, (i % 2 == 0) ? 32'd1 : 32'd0);
         checkOutput($sformatf("hold_dat%0d", i), datOut, 32'h12345678);
      end
      @(negedge clock);
      cyc = 1'b0; stb = 1'b0;

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
